// File: rtl/circuit1_hlsm_pkg.sv
// ============================================================================
// Module  : circuit1_hlsm_pkg
// Purpose : Shared definitions for the circuit1 HLSM: default datapath widths,
//           controller state encoding and shared-ALU operation select codes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package circuit1_hlsm_pkg;

  // Default operand / result widths (signed Int8 operands, signed Int16 result)
  localparam int DATA_W_DEFAULT = 8;
  localparam int RES_W_DEFAULT  = 16;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_S1    = 3'd1,
    ST_S2    = 3'd2,
    ST_S3    = 3'd3,
    ST_FINAL = 3'd4
  } state_e;

  // Operation applied by the single shared adder/subtractor
  typedef enum logic [1:0] {
    ALU_A_PLUS_B  = 2'd0,  // d = a + b
    ALU_A_PLUS_C  = 2'd1,  // e = a + c
    ALU_F_MINUS_D = 2'd2   // xwire = f - sext(d)
  } alu_op_e;

endpackage : circuit1_hlsm_pkg

`default_nettype wire

// File: rtl/circuit1_dp.sv
// ============================================================================
// Module  : circuit1_dp
// Purpose : Datapath for circuit1: operand registers, one shared
//           adder/subtractor, one multiplier, a signed comparator and the
//           result mux. Every register is enabled by the controller.
// Ports   : clk, rst        - clock, synchronous active-high reset
//           ld_ops          - capture a, b, c into operand registers
//           ld_d, ld_f      - capture d (ALU) and f (multiplier)
//           ld_e            - capture e (ALU)
//           ld_cmp          - capture g (d > e) and xwire (ALU)
//           ld_out          - load outputs z and x
//           alu_op          - shared ALU operation select (alu_op_e)
//           a, b, c         - signed operands
//           z, x            - registered results
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module circuit1_dp
  import circuit1_hlsm_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int RES_W  = RES_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_ops,
  input  logic              ld_d,
  input  logic              ld_f,
  input  logic              ld_e,
  input  logic              ld_cmp,
  input  logic              ld_out,
  input  logic [1:0]        alu_op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  output logic [DATA_W-1:0] z,
  output logic [RES_W-1:0]  x
);

  logic signed [DATA_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic signed [DATA_W-1:0] d_q, d_d, e_q, e_d, z_q, z_d;
  logic signed [RES_W-1:0]  f_q, f_d, xw_q, xw_d, x_q, x_d;
  logic                     g_q, g_d;

  logic signed [RES_W-1:0]    alu_a, alu_b, alu_y;
  logic                       alu_sub;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [RES_W-1:0]    prod_ext;

  // Single multiplier: full-precision signed product of the latched a and c
  assign prod = a_q * c_q;

  // Fit the 2*DATA_W product into the RES_W result width
  generate
    if (RES_W > 2*DATA_W) begin : g_prod_sext
      assign prod_ext = {{(RES_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    end else begin : g_prod_trunc
      assign prod_ext = prod[RES_W-1:0];
    end
  endgenerate

  // Shared adder/subtractor. Operands are sign-extended to RES_W so the
  // same unit serves the narrow d/e sums (low bits taken, wrapping) and
  // the wide f - sext(d) subtraction.
  always_comb begin
    alu_a   = {{(RES_W-DATA_W){a_q[DATA_W-1]}}, a_q};
    alu_b   = {{(RES_W-DATA_W){b_q[DATA_W-1]}}, b_q};
    alu_sub = 1'b0;
    case (alu_op)
      ALU_A_PLUS_C: begin
        alu_b = {{(RES_W-DATA_W){c_q[DATA_W-1]}}, c_q};
      end
      ALU_F_MINUS_D: begin
        alu_a   = f_q;
        alu_b   = {{(RES_W-DATA_W){d_q[DATA_W-1]}}, d_q};
        alu_sub = 1'b1;
      end
      default: ;
    endcase
    alu_y = alu_sub ? (alu_a - alu_b) : (alu_a + alu_b);
  end

  // Register next-state logic
  always_comb begin
    a_d  = ld_ops ? a : a_q;
    b_d  = ld_ops ? b : b_q;
    c_d  = ld_ops ? c : c_q;
    d_d  = ld_d   ? alu_y[DATA_W-1:0] : d_q;
    f_d  = ld_f   ? prod_ext : f_q;
    e_d  = ld_e   ? alu_y[DATA_W-1:0] : e_q;
    g_d  = ld_cmp ? (d_q > e_q) : g_q;   // signed compare; tie gives 0 -> e
    xw_d = ld_cmp ? alu_y : xw_q;
    z_d  = ld_out ? (g_q ? d_q : e_q) : z_q;
    x_d  = ld_out ? xw_q : x_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      c_q  <= '0;
      d_q  <= '0;
      f_q  <= '0;
      e_q  <= '0;
      g_q  <= 1'b0;
      xw_q <= '0;
      z_q  <= '0;
      x_q  <= '0;
    end else begin
      a_q  <= a_d;
      b_q  <= b_d;
      c_q  <= c_d;
      d_q  <= d_d;
      f_q  <= f_d;
      e_q  <= e_d;
      g_q  <= g_d;
      xw_q <= xw_d;
      z_q  <= z_d;
      x_q  <= x_d;
    end
  end

  assign z = z_q;
  assign x = x_q;

endmodule : circuit1_dp

`default_nettype wire

// File: rtl/circuit1_hlsm.sv
// ============================================================================
// Module  : circuit1_hlsm
// Purpose : Top of the circuit1 HLSM. A five-state controller sequences the
//           shared datapath to produce z = max_signed(a+b, a+c) and
//           x = a*c - (a+b).
// Ports   : Clk    - clock (rising edge)
//           Rst    - synchronous active-high reset
//           Start  - compute request, honoured only when idle
//           a,b,c  - signed operands, captured when Start is accepted
//           Busy   - high while a computation is in progress
//           Done   - one-cycle pulse when z and x are updated
//           z, x   - registered results, held between Done pulses
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module circuit1_hlsm
  import circuit1_hlsm_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int RES_W  = RES_W_DEFAULT
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  output logic              Busy,
  output logic              Done,
  output logic [DATA_W-1:0] z,
  output logic [RES_W-1:0]  x
);

  state_e     state_q, state_d;
  logic       done_q, done_d;

  logic       ld_ops, ld_d, ld_f, ld_e, ld_cmp, ld_out;
  logic [1:0] alu_op;

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    ld_ops  = 1'b0;
    ld_d    = 1'b0;
    ld_f    = 1'b0;
    ld_e    = 1'b0;
    ld_cmp  = 1'b0;
    ld_out  = 1'b0;
    alu_op  = ALU_A_PLUS_B;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          ld_ops  = 1'b1;
          state_d = ST_S1;
        end
      end
      ST_S1: begin
        alu_op  = ALU_A_PLUS_B;
        ld_d    = 1'b1;
        ld_f    = 1'b1;
        state_d = ST_S2;
      end
      ST_S2: begin
        alu_op  = ALU_A_PLUS_C;
        ld_e    = 1'b1;
        state_d = ST_S3;
      end
      ST_S3: begin
        alu_op  = ALU_F_MINUS_D;
        ld_cmp  = 1'b1;
        state_d = ST_FINAL;
      end
      ST_FINAL: begin
        ld_out  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Done is registered alongside z/x so it rises in the same cycle the new
  // results become visible (the cycle after leaving FINAL).
  assign done_d = (state_q == ST_FINAL);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  assign Busy = (state_q != ST_IDLE);
  assign Done = done_q;

  circuit1_dp #(
    .DATA_W (DATA_W),
    .RES_W  (RES_W)
  ) u_dp (
    .clk    (Clk),
    .rst    (Rst),
    .ld_ops (ld_ops),
    .ld_d   (ld_d),
    .ld_f   (ld_f),
    .ld_e   (ld_e),
    .ld_cmp (ld_cmp),
    .ld_out (ld_out),
    .alu_op (alu_op),
    .a      (a),
    .b      (b),
    .c      (c),
    .z      (z),
    .x      (x)
  );

endmodule : circuit1_hlsm

`default_nettype wire

// File: tb/tb_circuit1_hlsm.sv
// ============================================================================
// Module  : tb_circuit1_hlsm
// Purpose : Self-checking bench for circuit1_hlsm. A cycle-level reference
//           model computes z/x with plain integer arithmetic and tracks the
//           busy window as a countdown; directed cases plus random traffic.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_circuit1_hlsm;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  a, b, c;
  logic        busy, done;
  logic [7:0]  z;
  logic [15:0] x;

  int n_checks;
  int n_fail;

  // Reference model state
  int          cnt;      // cycles of busy remaining; 0 means idle
  logic        exp_done;
  logic [7:0]  exp_z, pend_z;
  logic [15:0] exp_x, pend_x;

  circuit1_hlsm dut (
    .Clk   (clk),
    .Rst   (rst),
    .Start (start),
    .a     (a),
    .b     (b),
    .c     (c),
    .Busy  (busy),
    .Done  (done),
    .z     (z),
    .x     (x)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // z = max(a+b, a+c) with 8-bit wrap, x = a*c - (a+b) with 16-bit wrap
  function automatic void ref_compute(input logic [7:0] ia, input logic [7:0] ib,
                                      input logic [7:0] ic,
                                      output logic [7:0] oz, output logic [15:0] ox);
    int  sa, sb, sc, f;
    byte d, e;
    sa = int'($signed(ia));
    sb = int'($signed(ib));
    sc = int'($signed(ic));
    d  = byte'(sa + sb);
    e  = byte'(sa + sc);
    f  = sa * sc;
    ox = 16'(f - int'(d));
    oz = (d > e) ? d : e;
  endfunction

  // One clock: advance the model at the edge, compare at the falling edge
  task automatic tick();
    @(posedge clk);
    exp_done = 1'b0;
    if (rst) begin
      cnt   = 0;
      exp_z = '0;
      exp_x = '0;
    end else if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        exp_z    = pend_z;
        exp_x    = pend_x;
        exp_done = 1'b1;
      end
    end else if (start) begin
      cnt = 4;
      ref_compute(a, b, c, pend_z, pend_x);
    end
    @(negedge clk);
    check_eq("busy", 32'(busy), 32'(cnt > 0));
    check_eq("done", 32'(done), 32'(exp_done));
    check_eq("z", 32'(z), 32'(exp_z));
    check_eq("x", 32'(x), 32'(exp_x));
  endtask

  // Directed transaction: one Start pulse, operands scrambled while busy,
  // results compared against the hand-computed constants as well.
  task automatic run_directed(input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] ic,
                              input logic [7:0] ez, input logic [15:0] ex);
    a = ia; b = ib; c = ic; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < 5; k++) begin
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
      start = 1'($urandom);   // Start while busy must be ignored
      tick();
    end
    start = 1'b0;
    check_eq("dir_done", 32'(done), 32'd1);
    check_eq("dir_z", 32'(z), 32'(ez));
    check_eq("dir_x", 32'(x), 32'(ex));
    tick();
  endtask

  initial begin
    int n_done;
    n_checks = 0;
    n_fail   = 0;
    cnt      = 0;
    exp_done = 1'b0;
    exp_z    = '0;
    exp_x    = '0;
    pend_z   = '0;
    pend_x   = '0;
    rst   = 1'b1;
    start = 1'b0;
    a = '0; b = '0; c = '0;

    // Reset state
    tick();
    tick();
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_z", 32'(z), 32'd0);
    check_eq("rst_x", 32'(x), 32'd0);
    rst = 1'b0;
    tick();

    // Directed cases: basic, wrap, tie
    run_directed(8'd5, 8'd3, 8'd2, 8'h08, 16'h0002);
    run_directed(8'd100, 8'd100, 8'h80, 8'hE4, 16'hCE38);
    run_directed(8'd0, 8'd4, 8'd4, 8'h04, 16'hFFFC);

    // Reset while in S2 aborts; z/x cleared, no Done afterwards
    a = 8'd7; b = 8'd9; c = 8'd11; start = 1'b1;
    tick();                 // now S1
    start = 1'b0;
    tick();                 // now S2
    rst = 1'b1;
    start = 1'b1;           // reset wins over Start
    tick();
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_z", 32'(z), 32'd0);
    check_eq("abort_x", 32'(x), 32'd0);
    rst = 1'b0;
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check_eq("abort_no_done", 32'(done), 32'd0);
    end

    // Start held high with operands changing every cycle
    n_done = 0;
    start  = 1'b1;
    for (int k = 0; k < 30; k++) begin
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
      tick();
      if (done) n_done++;
    end
    check_eq("b2b_done_count", 32'(n_done), 32'd6);
    start = 1'b0;
    for (int k = 0; k < 6; k++) tick();

    // Random traffic with occasional resets
    for (int k = 0; k < 3000; k++) begin
      a     = 8'($urandom);
      b     = 8'($urandom);
      c     = 8'($urandom);
      start = ($urandom_range(0, 3) != 0);
      rst   = ($urandom_range(0, 59) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_circuit1_hlsm

`default_nettype wire

// File: doc/circuit1_hlsm.md
CIRCUIT1_HLSM -- requirements
Module: circuit1_hlsm

Interface
REQ-001 Parameter DATA_W, default 8: operand width and z width; a, b, c, d, e are signed Int8.
REQ-002 Parameter RES_W, default 16: width of x and internal f, xwire; signed Int16.
REQ-003 Clk  input  1: single clock; all state updates on rising edge.
REQ-004 Rst  input  1: reset, synchronous and active-high.
REQ-005 Start  input  1: request to compute; sampled only in IDLE.
REQ-006 a, b, c  input  DATA_W each: signed operands; latched on accepted Start.
REQ-007 Busy  output  1: high whenever state is not IDLE.
REQ-008 Done  output  1: one-cycle pulse; z and x are valid.
REQ-009 z  output  DATA_W: registered result, z = (d > e) ? d : e.
REQ-010 x  output  RES_W: registered result, x = a*c - (a+b).

Function
REQ-011 States SHALL be IDLE, S1, S2, S3, FINAL.
REQ-012 IDLE -> S1 when Start=1, latching a, b, c into operand registers; otherwise stay in IDLE.
REQ-013 S1 SHALL compute d = a+b with the shared adder and f = a*c with the multiplier; S1 -> S2.
REQ-014 S2 SHALL compute e = a+c with the same shared adder; S2 -> S3.
REQ-015 S3 SHALL compute g = (d > e) signed and xwire = f - sext(d) with the shared adder/subtractor; S3 -> FINAL.
REQ-016 FINAL SHALL load z = g ? d : e and x = xwire, and assert Done; FINAL -> IDLE unconditionally.
REQ-017 Latency: with Start sampled high at edge N, Done SHALL be high in the cycle after edge N+4; initiation interval is 5 cycles.
REQ-018 d, e wrap modulo 2^DATA_W; f is the full signed 16-bit product; xwire wraps modulo 2^RES_W; d is sign-extended before subtraction.
REQ-019 d == e SHALL give g=0, so z=e.
REQ-020 Start while Busy=1, including in FINAL, SHALL be ignored; changes on a, b, c while Busy=1 SHALL NOT affect the result.
REQ-021 Start held high continuously SHALL restart a computation on every IDLE visit: back-to-back Done pulses 5 cycles apart.
REQ-022 z and x SHALL hold their last values between Done pulses.
REQ-023 Only one adder/subtractor and one multiplier SHALL be instantiated; the comparator and mux are separate.

Reset
REQ-024 Rst=1 at an edge SHALL force state IDLE and clear Busy, Done, z, x, and all internal registers to 0, regardless of state.
REQ-025 Rst mid-computation SHALL abort it; no Done SHALL follow for the aborted request.
REQ-026 Rst has priority over Start in the same cycle.

Structure
REQ-027 A shared package SHALL hold the state enumeration and the DATA_W/RES_W defaults.
REQ-028 The datapath SHALL be one sub-module, circuit1_dp: operand registers, shared adder/subtractor, multiplier, comparator, and mux. It is controlled by the FSM in circuit1_hlsm.

Verification
REQ-029 a=5, b=3, c=2, Start pulse -> Busy for 4 cycles, then Done with z=0x08, x=0x0002.
REQ-030 a=100, b=100, c=-128 (wrap case) -> d=-56, e=-28, z=0xE4, x=0xCE38.
REQ-031 a=0, b=4, c=4 (d==e) -> z=0x04, x=0xFFFC.
REQ-032 Rst asserted while in S2 -> next cycle IDLE; Busy=0, z=0, x=0, and no Done pulse.
REQ-033 Start held high, with operands changed every cycle -> Done every 5 cycles, each result matching the operands present at the accepting IDLE edge only.
